// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg : shared types, mode constants and one-hot helper for decoder_scan
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bit idx set when idx is inside the output width, otherwise all-zero.
  function automatic logic [63:0] onehot(input logic [5:0] idx, input int width);
    logic [63:0] v;
    v = '0;
    if (int'(idx) < width) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_tick.sv
// ----------------------------------------------------------------------------
// dwell_tick : modulo-DWELL counter with synchronous clear; o_tick on DWELL-1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dwell_tick #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  // DWELL=1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int              c_CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DWELL - 1);

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_CW'(1);
    end
  end

  assign o_tick = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/decoder_scan.sv
// ----------------------------------------------------------------------------
// decoder_scan : registered IN_W-to-2^IN_W one-hot decoder with auto-scan mode.
// Optional macro DECODER_OUT_ACTIVE_LOW_EN inverts Data_out (common-anode).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decoder_scan
  import decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Enable,
  input  logic                   Mode,
  input  logic [IN_W-1:0]        Data_in,
  input  logic [IN_W-1:0]        Scan_max,
  output logic [(1<<IN_W)-1:0]   Data_out,
  output logic [IN_W-1:0]        Index_out,
  output logic                   Wrap
);

  localparam int c_OUT_W = 1 << IN_W;

`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [c_OUT_W-1:0] c_POL = '1;
`else
  localparam logic [c_OUT_W-1:0] c_POL = '0;
`endif

  state_t               r_state;
  state_t               w_next_state;
  logic [IN_W-1:0]      r_index;
  logic [IN_W-1:0]      w_next_index;
  logic                 r_wrap;
  logic                 w_next_wrap;
  logic [c_OUT_W-1:0]   r_data_out;
  logic [c_OUT_W-1:0]   w_next_data;
  logic                 w_tick;
  logic                 w_dwell_clr;

  always_comb begin
    w_next_state = IDLE;
    if (Enable) w_next_state = (Mode == MODE_SCAN) ? SCAN : DIRECT;
  end

  // Dwell only runs while staying in SCAN, so every scan entry starts fresh.
  assign w_dwell_clr = !((r_state == SCAN) && (w_next_state == SCAN));

  dwell_tick #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_dwell_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_next_index = '0;
    w_next_wrap  = 1'b0;
    case (w_next_state)
      DIRECT: w_next_index = Data_in;
      SCAN: begin
        if (r_state == SCAN) begin
          if (w_tick) begin
            // >= lets a lowered Scan_max pull the index back instead of walking on.
            if (r_index >= Scan_max) begin
              w_next_index = '0;
              w_next_wrap  = 1'b1;
            end else begin
              w_next_index = r_index + IN_W'(1);
            end
          end else begin
            w_next_index = r_index;
          end
        end
      end
      default: ;
    endcase
    w_next_data = (w_next_state == IDLE) ? '0
                : c_OUT_W'(onehot(6'(w_next_index), c_OUT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_wrap     <= 1'b0;
      r_data_out <= c_POL;
    end else begin
      r_state    <= w_next_state;
      r_index    <= w_next_index;
      r_wrap     <= w_next_wrap;
      r_data_out <= w_next_data ^ c_POL;
    end
  end

  assign Data_out  = r_data_out;
  assign Index_out = r_index;
  assign Wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ----------------------------------------------------------------------------
// tb_decoder_scan : scoreboard bench for decoder_scan (IN_W=3, DWELL=4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decoder_scan;

  localparam int c_IN_W  = 3;
  localparam int c_DWELL = 4;
  localparam int c_OUT_W = 1 << c_IN_W;

`ifdef DECODER_OUT_ACTIVE_LOW_EN
  localparam logic [c_OUT_W-1:0] c_POL = '1;
`else
  localparam logic [c_OUT_W-1:0] c_POL = '0;
`endif

  typedef struct {
    logic [c_OUT_W-1:0] d;
    logic [c_IN_W-1:0]  i;
    logic               w;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                Enable;
  logic                Mode;
  logic [c_IN_W-1:0]   Data_in;
  logic [c_IN_W-1:0]   Scan_max;
  logic [c_OUT_W-1:0]  Data_out;
  logic [c_IN_W-1:0]   Index_out;
  logic                Wrap;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a position on the scan ring and how long it has been shown.
  bit   m_scanning = 0;
  int   m_pos      = 0;
  int   m_held     = 0;

  decoder_scan #(
    .IN_W  (c_IN_W),
    .DWELL (c_DWELL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (Enable),
    .Mode      (Mode),
    .Data_in   (Data_in),
    .Scan_max  (Scan_max),
    .Data_out  (Data_out),
    .Index_out (Index_out),
    .Wrap      (Wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
    end
  endtask

  // Apply one cycle of inputs and predict what the outputs show after the edge.
  task automatic drive(input logic rn, input logic en, input logic md,
                       input int din, input int smax);
    exp_t e;
    int   idx;
    bit   wr;
    bit   active;
    @(negedge clk);
    rst_n    = rn;
    Enable   = en;
    Mode     = md;
    Data_in  = c_IN_W'(din);
    Scan_max = c_IN_W'(smax);
    idx    = 0;
    wr     = 0;
    active = 0;
    if (!rn || !en) begin
      m_scanning = 0;
    end else if (!md) begin
      m_scanning = 0;
      idx        = din;
      active     = 1;
    end else if (!m_scanning) begin
      m_scanning = 1;
      m_pos      = 0;
      m_held     = 0;
      active     = 1;
    end else begin
      m_held++;
      if (m_held == c_DWELL) begin
        m_held = 0;
        if (m_pos >= smax) begin
          m_pos = 0;
          wr    = 1;
        end else begin
          m_pos++;
        end
      end
      idx    = m_pos;
      active = 1;
    end
    e.d = (active ? (c_OUT_W'(1) << idx) : '0) ^ c_POL;
    e.i = c_IN_W'(idx);
    e.w = wr;
    q.push_back(e);
  endtask

  // Monitor: one registered output set per edge, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("Data_out",  64'(Data_out),  64'(e.d));
        check("Index_out", 64'(Index_out), 64'(e.i));
        check("Wrap",      64'(Wrap),      64'(e.w));
      end
    end
  end

  initial begin
    logic en;
    logic md;
    logic rn;
    int   smax;
    rst_n    = 1'b0;
    Enable   = 1'b1;
    Mode     = 1'b1;
    Data_in  = '0;
    Scan_max = '0;

    // Reset held with scan requested
    repeat (2) drive(0, 1, 1, 0, 7);
    // Direct decode of every index
    for (int k = 0; k < 8; k++) drive(1, 1, 0, k, 7);
    // Disable drops the outputs and ignores Data_in
    drive(1, 1, 0, 2, 7);
    drive(1, 0, 0, 2, 7);
    repeat (3) drive(1, 0, 0, 7, 7);
    // Full scan with wrap at cycle 32
    repeat (40) drive(1, 1, 1, 0, 7);
    // Lower Scan_max below the current index
    drive(1, 0, 1, 0, 7);
    repeat (22) drive(1, 1, 1, 0, 7);
    repeat (30) drive(1, 1, 1, 0, 2);
    // Scan_max = 0 wraps every DWELL cycles
    repeat (14) drive(1, 1, 1, 0, 0);
    // Reset mid-scan, then scan restart
    drive(1, 0, 1, 0, 7);
    repeat (17) drive(1, 1, 1, 0, 7);
    drive(0, 1, 1, 0, 7);
    repeat (8) drive(1, 1, 1, 0, 7);
    // Mode toggles mid-scan
    repeat (6) drive(1, 1, 1, 0, 7);
    drive(1, 1, 0, 5, 7);
    repeat (6) drive(1, 1, 1, 0, 7);

    // Randomised traffic with sticky controls so scans get time to progress
    en   = 1;
    md   = 1;
    smax = 7;
    for (int k = 0; k < 2000; k++) begin
      rn = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 3) en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 4) md = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) smax = $urandom_range(0, 7);
      drive(rn, en, md, $urandom_range(0, 7), smax);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered IN_W-to-2^IN_W one-hot decoder.
- Next generation of the 3-8 decoder: generic width, registered outputs, enable, and an auto-scan mode.
- In scan mode an internal index steps across outputs 0..Scan_max, holding each position for DWELL cycles. Intended to drive LED/7-segment digit-select lines in the lab board top level.

Parameters:
- IN_W, 3, select width; output width is 2^IN_W; legal range 1..6.
- DWELL, 4, clock cycles each scan position is held; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- Enable  input  1  1 = outputs active; 0 = all outputs deasserted.
- Mode  input  1  0 = direct decode of Data_in; 1 = auto-scan.
- Data_in  input  IN_W  select index in direct mode; ignored in scan mode.
- Scan_max  input  IN_W  last index visited in scan mode; sampled every cycle.
- Data_out  output  2^IN_W  registered one-hot output (all-zero when idle).
- Index_out  output  IN_W  registered index currently driven on Data_out.
- Wrap  output  1  one-cycle pulse when the scan index returns to 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Every register updates only on the rising edge of clk.
- Reset (rst_n=0 at an edge): Data_out=0, Index_out=0, Wrap=0, dwell counter=0, state=IDLE. Reset overrides all other inputs.
- State register values are IDLE, DIRECT and SCAN. Next state is IDLE if Enable=0, DIRECT if Enable=1 and Mode=0, SCAN if Enable=1 and Mode=1. Transitions take effect at the next edge.
- IDLE: Data_out=0, Index_out=0, Wrap=0; dwell counter and scan index cleared.
- DIRECT: Data_out <= 1<<Data_in and Index_out <= Data_in. Latency is 1 cycle. Wrap=0. Dwell counter is held at 0.
- SCAN entry (previous state is not SCAN): in the first SCAN cycle, Data_out=1<<0, Index_out=0, dwell=0, and Wrap=0.
- SCAN steady state:
  - The dwell counter counts 0..DWELL-1.
  - When dwell==DWELL-1, the counter returns to 0 and the index advances.
  - If index >= Scan_max at the advance, the index becomes 0 and Wrap=1 in that same cycle. Otherwise the index increments by 1 and Wrap=0.
  - The comparison is >= so that lowering Scan_max below the current index forces a wrap at the next advance, never an out-of-range walk.
- Scan_max=0: output stays at bit 0 and Wrap pulses once every DWELL cycles.
- DWELL=1: the index advances every cycle.
- Mode 1->0 mid-scan: the next cycle is a direct decode. Mode 0->1: scan restarts at index 0.
- Enable 1->0: Data_out=0 in the next cycle. Scan position is lost; re-entry restarts at 0.
- Reset mid-scan: all outputs go to 0 at that edge. After release, scan entry starts at index 0.
- Data_out is always exactly one-hot or all-zero, and always agrees with Index_out.

Optional Feature:
- Macro: DECODER_OUT_ACTIVE_LOW_EN.
- Defined: Data_out is inverted for common-anode hardware. The reset and idle value becomes all-ones, and the active bit is 0. Index_out and Wrap are unchanged.
- Undefined: active-high output as described above.
- Inversion is applied at the output register, so latency is unchanged.

Decomposition:
- Package decoder_pkg contains:
  - enum state_t {IDLE, DIRECT, SCAN};
  - constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1;
  - function onehot(idx, width).
- One sub-module: dwell_tick (parametrised DWELL counter with synchronous clear; outputs a tick on the DWELL-1 count).
- Index register, state machine and output register stay in decoder_scan.

Test Plan (IN_W=3, DWELL=4):
1. rst_n=0 for 2 cycles with Enable=1, Mode=1 -> Data_out=8'h00, Index_out=0, Wrap=0 throughout reset.
2. Enable=1, Mode=0, Data_in stepped 0..7 one per cycle -> Data_out is 8'h01, 8'h02, ... 8'h80, each 1 cycle after its input. With DECODER_OUT_ACTIVE_LOW_EN defined -> 8'hFE .. 8'h7F.
3. Data_in=3'b010, then Enable=0, then Data_in=3'b111 -> Data_out=8'h04, then 8'h00, and it stays 8'h00.
4. Mode=1, Scan_max=7 -> each of 8'h01..8'h80 is held 4 cycles. In cycle 32 after entry, Data_out=8'h01 with Wrap=1 for exactly 1 cycle.
5. Scan_max=7, index reaches 5, then Scan_max is set to 2 -> at the next advance Data_out=8'h01, Index_out=0, Wrap=1. Afterwards the scan cycles 01/02/04.
6. Scan at index 4 (8'h10), rst_n=0 for 1 cycle -> Data_out=8'h00. After release with Mode=1, scan restarts at 8'h01 for 4 cycles.
